// File: rtl/ysyx_2022040010_shift_pkg.sv
// Shared definitions for the iterative shift unit: op encodings, FSM states
// and the shift-amount width helper.
package ysyx_2022040010_shift_pkg;

    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b001;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic int shw_of(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic logic op_valid(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/ysyx_2022040010_shift_iter_if.sv
// Request/response handshake bundle of the iterative shift unit.
interface ysyx_2022040010_shift_iter_if
    import ysyx_2022040010_shift_pkg::*;
#(
    parameter int XLEN = 64
);
    localparam int SHW = shw_of(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src;
    logic [SHW-1:0]  shamt;
    logic [2:0]      op;
    logic            word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, src, shamt, op, word, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, src, shamt, op, word, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/ysyx_2022040010_shift_step.sv
// Combinational single-step shifter: moves an XLEN-bit value by 0..STEP bits,
// left with zero fill or right with a caller-supplied fill bit.
module ysyx_2022040010_shift_step #(
    parameter  int XLEN = 64,
    parameter  int STEP = 4,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] value,
    input  logic [KW-1:0]   k,
    input  logic            dir,
    input  logic            fill,
    output logic [XLEN-1:0] result
);

    always_comb begin
        if (dir) begin
            result = (value >> k) | ({XLEN{fill}} & ~({XLEN{1'b1}} >> k));
        end else begin
            result = value << k;
        end
    end

endmodule

// File: rtl/ysyx_2022040010_shift_iter.sv
// Multi-cycle SLL/SRL/SRA (+ RV64 W variants) shifting at most STEP bits per
// cycle, with valid/ready on both sides and a synchronous flush.
module ysyx_2022040010_shift_iter
    import ysyx_2022040010_shift_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STEP = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    input logic                          flush,
    ysyx_2022040010_shift_iter_if.slave  io
);

    localparam int SHW = shw_of(XLEN);
    localparam int KW  = $clog2(STEP + 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [SHW-1:0]  rem_q, rem_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            sign_q, sign_d;
    logic            out_valid_q, out_valid_d;

    logic [SHW-1:0]  n_in;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] step_out;
    logic [KW-1:0]   k;
    logic            dir_right;
    logic            fill_bit;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int unsigned i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[i] : v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int unsigned i = 0; i < XLEN; i++) r[i] = (i < 32) ? v[i] : 1'b0;
        return r;
    endfunction

    // Word-mode operand preparation happens at accept so the shift loop is width-agnostic.
    always_comb begin
        n_in    = io.word ? (io.shamt & SHW'(31)) : io.shamt;
        operand = io.src;
        if (io.word) begin
            if (io.op == OP_SRL)      operand = zext32(io.src);
            else if (io.op == OP_SRA) operand = sext32(io.src);
        end
    end

    always_comb begin
        if (int'(rem_q) > STEP) k = KW'(STEP);
        else                    k = KW'(rem_q);
        dir_right = (op_q != OP_SLL);
        fill_bit  = (op_q == OP_SRA) && sign_q;
    end

    ysyx_2022040010_shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .value  (work_q),
        .k      (k),
        .dir    (dir_right),
        .fill   (fill_bit),
        .result (step_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        rem_d    = rem_q;
        op_d     = op_q;
        word_d   = word_q;
        sign_d   = sign_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    op_d   = io.op;
                    word_d = io.word;
                    sign_d = operand[XLEN-1];
                    rem_d  = n_in;
                    work_d = operand;
                    if (!op_valid(io.op)) begin
                        work_d   = '0;
                        rem_d    = '0;
                        result_d = '0;
                        state_d  = DONE;
                    end else if (n_in == '0) begin
                        result_d = io.word ? sext32(operand) : operand;
                        state_d  = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - SHW'(k);
                if (rem_d == '0) begin
                    result_d = word_q ? sext32(step_out) : step_out;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            work_d  = '0;
            rem_d   = '0;
        end

        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            result_q    <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            result_q    <= result_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            word_q      <= word_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;

endmodule
